alu_64bit: RTL and testbench

64-bit two-operand ALU computing NOR, XOR, add-with-carry or subtract-with-borrow on `a`/`b`, selected by a 2-bit opcode. It is the datapath arithmetic unit: a ripple chain of 64 identical 1-bit slices, with the result and carry/borrow captured in an output register. Consumers read `s`/`cout` one clock after the operands and opcode are presented.

---
 rtl/alu_64bit_if.sv | 15 +
 rtl/alu_64bit.sv | 54 +++++
 tb/tb_alu_64bit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_64bit_if.sv
// Operand/opcode/result bundle for the 64-bit ALU.
// The master drives operands and opcode; the slave returns the registered result.
interface alu_64bit_if;
  localparam int unsigned W = 64;

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   op;
  logic [W-1:0] s;
  logic         cout;

  modport master (output a, output b, output cin, output op, input s, input cout);
  modport slave  (input a, input b, input cin, input op, output s, output cout);
endinterface

// File: rtl/alu_64bit.sv
// 64-bit NOR/XOR/ADD/SUB unit built from a ripple chain of 1-bit slices.
// The result and carry/borrow are registered, giving one cycle of latency.
module alu_64bit (
  input  logic        clk,
  input  logic        rst,
  alu_64bit_if.slave  bus
);
  localparam int unsigned W = 64;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;

  logic [W-1:0] s_d;
  logic [W-1:0] s_q;
  logic         cout_d;
  logic         cout_q;
  logic [W:0]   chain;

  // Ripple chain: op[0] selects borrow (SUB) versus carry (ADD) per slice
  always_comb begin
    chain    = '0;
    s_d      = '0;
    cout_d   = 1'b0;
    chain[0] = bus.cin;
    for (int i = 0; i < W; i++) begin
      if (bus.op[0]) begin
        chain[i+1] = (~bus.a[i] & bus.b[i]) | (~bus.a[i] & chain[i]) | (bus.b[i] & chain[i]);
      end else begin
        chain[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & chain[i]) | (bus.b[i] & chain[i]);
      end
    end
    case (bus.op)
      OP_NOR:  s_d = ~(bus.a | bus.b);
      OP_XOR:  s_d = bus.a ^ bus.b;
      default: begin
        s_d    = bus.a ^ bus.b ^ chain[W-1:0];
        cout_d = chain[W];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed corner cases plus random
// vectors compared against a 65-bit arithmetic reference model.
module tb_alu_64bit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_64bit_if bus ();

  alu_64bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic [1:0] op);
    logic [64:0] r;
    case (op)
      2'd0:    r = {1'b0, ~(a | b)};
      2'd1:    r = {1'b0, a ^ b};
      2'd2:    r = {1'b0, a} + {1'b0, b} + 65'(cin);
      default: r = {1'b0, a} - {1'b0, b} - 65'(cin);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] es, input logic ec);
    checks++;
    assert ({bus.cout, bus.s} === {ec, es}) else begin
      failures++;
      $error("FAIL %s: got s=%h cout=%b, expected s=%h cout=%b", tag, bus.s, bus.cout, es, ec);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic [1:0] op);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.op  = op;
  endtask

  task automatic step_dir(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic [1:0] op,
                          input logic [63:0] es, input logic ec);
    drive(a, b, cin, op);
    @(posedge clk);
    #1;
    check(tag, es, ec);
  endtask

  initial begin
    logic [64:0] exp_r;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [1:0]  rop;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.a    = 64'hDEAD_BEEF_0123_4567;
    bus.b    = 64'h1;
    bus.cin  = 1'b1;
    bus.op   = 2'b10;

    // Reset holds outputs at zero even across a clock edge
    #7;
    check("reset_state", 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step_dir("add_msb_lsb", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 2'b10,
             64'h8000_0000_0000_0001, 1'b0);
    step_dir("sub_msb_1", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 2'b11,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    step_dir("nor_zero", 64'h0, 64'h0, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step_dir("xor_pattern", 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 1'b1, 2'b01,
             64'hF0F00F0FF0F00F0F, 1'b0);
    step_dir("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2'b10, 64'h0, 1'b1);
    step_dir("sub_wrap", 64'h0, 64'h1, 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step_dir("sub_eq_borrow", 64'h5, 64'h5, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step_dir("nor_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2'b00, 64'h0, 1'b0);

    // Asynchronous reset between edges, then release and reload
    step_dir("add_pre_rst", 64'h1234, 64'h0F00, 1'b1, 2'b10, 64'h2135, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 64'h0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held_edge", 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_released_no_edge", 64'h0, 1'b0);
    @(posedge clk);
    #1;
    check("first_load_after_rst", 64'h2135, 1'b0);

    // Opcode change between edges takes effect only on the next edge
    step_dir("lat_add", 64'h10, 64'h20, 1'b0, 2'b10, 64'h30, 1'b0);
    #2;
    bus.op = 2'b11;
    #1;
    check("lat_hold_add", 64'h30, 1'b0);
    @(posedge clk);
    #1;
    check("lat_sub", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra  = {$urandom, $urandom};
      rb  = (n % 8 == 0) ? ra : {$urandom, $urandom};
      rc  = 1'($urandom);
      rop = (n % 4 == 3) ? 2'($urandom) : {1'b1, 1'($urandom)};
      drive(ra, rb, rc, rop);
      exp_r = ref_model(ra, rb, rc, rop);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_op%0d", n, rop), exp_r[63:0], exp_r[64]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
